// File: rtl/result_writeback.sv
// Result write-back stage for the operand-RAM datapath loop.
// Each issued micro-op's destination rides a LATENCY-deep delay line. When the
// matching postadder result emerges, it is written into the operand RAM port.
// A RAW scoreboard tells the issue side whether an address still has a write in flight.
module result_writeback #(
    parameter int DW      = 321,
    parameter int AW      = 9,
    parameter int LATENCY = 16,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_dst,
    input  logic [DW-1:0] res_data,
    input  logic [AW-1:0] rd_addr,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic          rd_hazard,
    output logic          busy,
    output logic          drain_done,
    output logic [CW-1:0] wr_count
);

    // Pending writes can reach LATENCY+1: LATENCY ops in the delay line plus one
    // op sitting in the write register.
    localparam int PW = $clog2(LATENCY + 2);

    // A slot carries a write only when it is both valid and writing; bubbles are dropped here.
    logic issue_wr;
    assign issue_wr = issue_valid & issue_we;

    // Delay line state: stage k holds the op issued k+1 cycles ago.
    logic [LATENCY-1:0] stage_v_reg;
    logic [AW-1:0]      stage_dst_reg [LATENCY];

    // Write-stage registers that drive the RAM port.
    logic               ram_wea_reg;
    logic [AW-1:0]      ram_addra_reg;
    logic [DW-1:0]      ram_dina_reg;

    // In-flight bookkeeping.
    logic [PW-1:0]      pending_reg;
    logic [PW-1:0]      pending_next;
    logic               busy_reg;
    logic               drain_done_reg;
    logic [CW-1:0]      wr_count_reg;

    // Per-stage address match against the read the issue side wants to do.
    logic [LATENCY-1:0] stage_hit;
    logic               issue_hit;
    logic               write_hit;

    // Delay line: shifts every cycle; there is no stall path.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_v_reg <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                stage_dst_reg[k] <= '0;
            end
        end else begin
            stage_v_reg[0]   <= issue_wr;
            stage_dst_reg[0] <= issue_dst;
            for (int k = 1; k < LATENCY; k++) begin
                stage_v_reg[k]   <= stage_v_reg[k-1];
                stage_dst_reg[k] <= stage_dst_reg[k-1];
            end
        end
    end

    // Write stage: capture the result in the cycle it emerges, present it to the RAM next cycle.
    // Address and data hold their last values on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wea_reg   <= 1'b0;
            ram_addra_reg <= '0;
            ram_dina_reg  <= '0;
        end else begin
            ram_wea_reg <= stage_v_reg[LATENCY-1];
            if (stage_v_reg[LATENCY-1]) begin
                ram_addra_reg <= stage_dst_reg[LATENCY-1];
                ram_dina_reg  <= res_data;
            end
        end
    end

    // Pending count: issues add, completed writes subtract, both together cancel out.
    always_comb begin
        pending_next = pending_reg;
        case ({issue_wr, ram_wea_reg})
            2'b10:   pending_next = pending_reg + PW'(1);
            2'b01:   pending_next = pending_reg - PW'(1);
            default: pending_next = pending_reg;
        endcase
    end

    // Count, busy flag and drain pulse all update together from the next-count value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg    <= '0;
            busy_reg       <= 1'b0;
            drain_done_reg <= 1'b0;
        end else begin
            pending_reg    <= pending_next;
            busy_reg       <= (pending_next != '0);
            drain_done_reg <= (pending_reg == PW'(1)) && (pending_next == '0);
        end
    end

    // Lifetime write counter; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (ram_wea_reg) begin
            wr_count_reg <= wr_count_reg + CW'(1);
        end
    end

    // One comparator per delay stage.
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage_hit
            assign stage_hit[gi] = stage_v_reg[gi] && (stage_dst_reg[gi] == rd_addr);
        end
    endgenerate

    // The issue term covers the op entering this cycle; the write term covers the
    // read/write collision on the RAM itself in the cycle the write lands.
    assign issue_hit = issue_wr && (issue_dst == rd_addr);
    assign write_hit = ram_wea_reg && (ram_addra_reg == rd_addr);
    assign rd_hazard = issue_hit | write_hit | (|stage_hit);

    assign ram_wea    = ram_wea_reg;
    assign ram_addra  = ram_addra_reg;
    assign ram_dina   = ram_dina_reg;
    assign busy       = busy_reg;
    assign drain_done = drain_done_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback with a write scoreboard and a small
// in-flight model for busy/drain/hazard expectations.
module tb_result_writeback;

    localparam int DW = 321;
    localparam int AW = 9;
    localparam int LAT = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic          issue_we;
    logic [AW-1:0] issue_dst;
    logic [DW-1:0] res_data;
    logic [AW-1:0] rd_addr;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          rd_hazard;
    logic          busy;
    logic          drain_done;
    logic [CW-1:0] wr_count;

    result_writeback #(.DW(DW), .AW(AW), .LATENCY(LAT), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dst   (issue_dst),
        .res_data    (res_data),
        .rd_addr     (rd_addr),
        .ram_wea     (ram_wea),
        .ram_addra   (ram_addra),
        .ram_dina    (ram_dina),
        .rd_hazard   (rd_hazard),
        .busy        (busy),
        .drain_done  (drain_done),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        int            wcyc;
    } wr_t;

    wr_t           q[$];
    int            nvec = 0;
    int            nfail = 0;
    int            cyc = 0;
    int            prev_pend = 0;
    logic [CW-1:0] wcount = '0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int            forced_cyc = -1;
    logic [DW-1:0] forced_data = '0;

    function automatic logic [DW-1:0] data_of(input int c);
        logic [351:0] w;
        if (c == forced_cyc) return forced_data;
        for (int k = 0; k < 11; k++) begin
            w[k*32 +: 32] = (32'(c) * 32'h9E3779B1) ^ (32'(k) << 20) ^ 32'h5A5A0000;
        end
        return w[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s cyc=%0d got %0h want %0h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance.
    task automatic step(input logic iv, input logic iwe, input logic [AW-1:0] idst,
                        input logic [AW-1:0] raddr);
        int   pend;
        logic exp_wea;
        logic exp_hz;
        issue_valid = iv;
        issue_we    = iwe;
        issue_dst   = idst;
        rd_addr     = raddr;
        res_data    = data_of(cyc);
        #1;
        pend    = q.size();
        exp_wea = (pend > 0) && (q[0].wcyc == cyc);
        exp_hz  = iv && iwe && (idst == raddr);
        foreach (q[i]) begin
            if (q[i].wcyc >= cyc && q[i].dst == raddr) exp_hz = 1'b1;
        end
        if (exp_wea) begin
            last_addr = q[0].dst;
            last_data = q[0].data;
        end
        chk("ram_wea", DW'(ram_wea), DW'(exp_wea));
        chk("ram_addra", DW'(ram_addra), DW'(last_addr));
        chk("ram_dina", ram_dina, last_data);
        chk("rd_hazard", DW'(rd_hazard), DW'(exp_hz));
        chk("busy", DW'(busy), DW'(pend != 0));
        chk("drain_done", DW'(drain_done), DW'(prev_pend == 1 && pend == 0));
        chk("wr_count", DW'(wr_count), DW'(wcount));
        $display("cyc=%0d iv=%0b we=%0b dst=%0h rd=%0h wea=%0b addra=%0h hz=%0b busy=%0b drain=%0b wrc=%0d",
                 cyc, iv, iwe, idst, raddr, ram_wea, ram_addra, rd_hazard, busy, drain_done, wr_count);
        if (exp_wea) begin
            void'(q.pop_front());
            wcount = wcount + 1'b1;
        end
        prev_pend = pend;
        if (iv && iwe) q.push_back('{idst, data_of(cyc + LAT), cyc + LAT + 1});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [AW-1:0] raddr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, raddr);
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        q.delete();
        wcount    = '0;
        prev_pend = 0;
        last_addr = '0;
        last_data = '0;
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dst   = '0;
        res_data    = '0;
        rd_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        idle(2, 9'h000);

        // Single op with a known result value
        forced_cyc  = cyc + LAT;
        forced_data = DW'(12'hABC);
        step(1'b1, 1'b1, 9'h005, 9'h000);
        idle(20, 9'h000);
        chk("single_wr_count", DW'(wr_count), DW'(4'd1));

        // Burst of 16 back-to-back issues
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 9'(i), 9'h100);
        idle(20, 9'h100);

        // Hazard tracking from issue through the write cycle
        step(1'b1, 1'b1, 9'h01F, 9'h01F);
        idle(18, 9'h01F);
        step(1'b1, 1'b1, 9'h01F, 9'h020);
        idle(18, 9'h020);

        // NOPs and bubbles never write and never flag a hazard
        step(1'b1, 1'b1, 9'h003, 9'h003);
        step(1'b1, 1'b0, 9'h004, 9'h004);
        step(1'b1, 1'b1, 9'h005, 9'h005);
        step(1'b0, 1'b1, 9'h007, 9'h007);
        idle(10, 9'h004);
        idle(10, 9'h007);

        // Reset with ops in flight: nothing may land afterwards
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 9'(8'h40 + i), 9'h000);
        do_reset();
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_wr_count", DW'(wr_count), DW'(4'd0));
        idle(25, 9'h041);

        // Counter wrap: 17 writes into a 4-bit counter, with repeated destinations
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 9'(i % 3), 9'h002);
        idle(20, 9'h002);
        chk("wrap_wr_count", DW'(wr_count), DW'(4'd1));

        // Sustained issue overlapping writes: pending stays flat at its peak
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 9'(9'h080 + (i % 5)), 9'h081);
        idle(20, 9'h081);

        if (q.size() != 0) begin
            nfail++;
            $error("FAIL scoreboard_empty got %0d want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
